systolic_tile_sched: RTL and testbench
======================================

Name: systolic_tile_sched

Overview:
- Tile sequencer for the size x size systolic MAC array and its per-row x FIFOs and per-column w FIFOs.
- On start it:
  - clears the accumulators;
  - issues diagonally skewed FIFO reads so row/column i enters the array i cycles after row/column 0;
  - holds mac_en until the wavefront has flushed through;
  - drains the result rows over a valid/ready handshake.
- Sits between the host command interface and the array/FIFO datapath.

Parameters:
- size, 16, array dimension (rows = columns = FIFOs per operand); must be >= 2.
- depth, 16, maximum reduction length k per tile (FIFO depth).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  $clog2(depth+1)  reduction length; captured when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last drain transfer
- acc_clr  out  1  clear all PE accumulators
- mac_en  out  1  array advance/accumulate enable
- x_fifo_empty  in  size (unpacked)  per-row x FIFO empty
- w_fifo_empty  in  size (unpacked)  per-column w FIFO empty
- x_fifo_ren  out  size (unpacked)  per-row x FIFO read enable
- w_fifo_ren  out  size (unpacked)  per-column w FIFO read enable
- out_val  in/out: out  1  result row valid
- out_rdy  in  1  consumer ready for result row
- out_row  out  $clog2(size)  index of the row currently presented

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - busy, done, acc_clr, mac_en, out_val = 0; out_row = 0.
  - All ren = 0; all counters = 0.
  - Reset asserted mid-tile aborts the tile immediately. No partial drain; FIFO contents are left as-is.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN. All outputs are registered or decoded from state/counters; no combinational path from out_rdy to out_val.
- IDLE:
  - start = 1 latches k_len into k_reg and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - One cycle, acc_clr = 1, mac_en = 0.
  - Next state is FEED if k_reg != 0, else DRAIN (all-zero result).
- FEED:
  - Counter t runs from 0 to k_reg+size-2.
  - Row i is "due" when i <= t < i+k_reg: x_fifo_ren[i] is requested; the same rule applies to column j and w_fifo_ren[j].
  - Stall: if any due FIFO is empty this cycle, then all ren = 0, mac_en = 0 and t holds.
  - Otherwise all due ren = 1, mac_en = 1 and t increments.
  - Reads are never issued to an empty FIFO and never to a non-due FIFO.
  - After the non-stalled cycle with t = k_reg+size-2, go to FLUSH.
- FLUSH:
  - Counter f runs for size-1 cycles with mac_en = 1 and no reads; then go to DRAIN.
  - Total mac_en-high cycles per tile = k_reg + 2*(size-1), independent of stalls.
- DRAIN:
  - out_val = 1 with out_row = r, r from 0 to size-1.
  - mac_en = 0.
  - A transfer occurs on out_val & out_rdy, then r increments.
  - out_val stays high and out_row stable while out_rdy = 0.
  - After the transfer at r = size-1: out_val = 0, done = 1 for one cycle, go to IDLE (busy = 0 in that same cycle).
- Simultaneous start and done: start arriving in the done cycle is ignored; start is only accepted from the following cycle.
- k_len > depth: clamped to depth on capture.

Optional Feature:
- Macro: SYSTOLIC_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cnt [15:0] counting FEED stall cycles in the current tile.
  - Cleared in CLEAR; saturates at 16'hFFFF; holds its value through DRAIN and IDLE.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (size=4, depth=8):
- Basic tile: start, k_len=3, all FIFOs non-empty, out_rdy=1 -> acc_clr for 1 cycle; FEED 6 cycles with ren[0] high at t=0..2 and ren[3] high at t=3..5; mac_en high 9 cycles total; out_row 0..3 on 4 consecutive cycles; done 1 cycle later.
- Stall: k_len=3, x_fifo_empty[2]=1 when t=2 for 3 cycles -> all ren and mac_en low for those 3 cycles with t held; ren per FIFO totals exactly 3; mac_en total still 9; stall_cnt=3 when SYSTOLIC_SCHED_PERF_EN is defined.
- Back-pressure: out_rdy=0 for 5 cycles at row 1 -> out_val held high, out_row=1 stable; rows 2 and 3 follow once out_rdy=1; exactly 4 transfers.
- Zero length: k_len=0 -> CLEAR then DRAIN directly; no ren and no mac_en ever asserted; 4 rows drained; done pulses.
- Reset mid-FEED: rst low at t=4 -> same cycle all outputs 0, busy=0; new start after release runs a full clean tile.
- Ignored start: start pulsed during FEED and during the done cycle -> no restart; busy and ren sequence unchanged.

Source files
------------

// File: rtl/systolic_tile_sched.sv
// Tile sequencer for a size x size systolic MAC array.
// Clears the accumulators, issues diagonally skewed reads to the per-row x FIFOs
// and per-column w FIFOs, keeps the array running until the wavefront has
// flushed, then drains result rows over a valid/ready handshake.
// Optional macro SYSTOLIC_SCHED_PERF_EN adds the stall_cnt output.
module systolic_tile_sched #(
  parameter int size  = 16,
  parameter int depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(depth+1)-1:0] k_len,
  output logic                       busy,
  output logic                       done,
  output logic                       acc_clr,
  output logic                       mac_en,
  input  logic                       x_fifo_empty [size],
  input  logic                       w_fifo_empty [size],
  output logic                       x_fifo_ren   [size],
  output logic                       w_fifo_ren   [size],
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(size)-1:0]    out_row
`ifdef SYSTOLIC_SCHED_PERF_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int KW = $clog2(depth + 1);
  // t reaches k_reg+size-2 <= depth+size-2, so depth+size codes are enough
  localparam int TW = $clog2(depth + size);
  localparam int RW = $clog2(size);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [TW-1:0]   t;
  logic [RW-1:0]   f;
  logic [RW-1:0]   r;
  logic [KW-1:0]   k_cap;
  logic [TW-1:0]   t_last;
  logic [size-1:0] due;
  logic [size-1:0] blocked;
  logic            in_feed;
  logic            stall;

  // Oversized reduction lengths are clamped to what the FIFOs can hold.
  assign k_cap  = (k_len > KW'(depth)) ? KW'(depth) : k_len;
  assign t_last = TW'(k_reg) + TW'(size - 2);
  assign in_feed = (state == FEED);

  // Per-lane wavefront window: lane i is due while i <= t < i+k_reg.
  // Row i and column i share the same window, so one decode serves both FIFOs.
  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [TW:0] t_x;
    logic [TW:0] hi;
    assign t_x = {1'b0, t};
    assign hi  = (TW+1)'(i) + (TW+1)'(k_reg);
    assign due[i] = in_feed && (t_x >= (TW+1)'(i)) && (t_x < hi);
    // A due lane with either operand FIFO empty holds the whole wavefront.
    assign blocked[i] = due[i] && (x_fifo_empty[i] || w_fifo_empty[i]);
    assign x_fifo_ren[i] = due[i] && !stall;
    assign w_fifo_ren[i] = due[i] && !stall;
  end

  assign stall = |blocked;

  // Status and array controls decoded from state; out_val never sees out_rdy.
  assign busy    = (state != IDLE);
  assign acc_clr = (state == CLEAR);
  assign out_val = (state == DRAIN);
  assign out_row = r;
  assign mac_en  = (in_feed && !stall) || (state == FLUSH);

  // Tile sequencing FSM with its t/f/r counters and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k_reg <= '0;
      t     <= '0;
      f     <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            k_reg <= k_cap;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          t     <= '0;
          f     <= '0;
          r     <= '0;
          state <= (k_reg != '0) ? FEED : DRAIN;
        end
        FEED: begin
          if (!stall) begin
            if (t == t_last) begin
              t     <= '0;
              state <= FLUSH;
            end else begin
              t <= t + TW'(1);
            end
          end
        end
        FLUSH: begin
          // size-1 cycles let the last operands reach the far corner PE.
          if (f == RW'(size - 2)) begin
            f     <= '0;
            state <= DRAIN;
          end else begin
            f <= f + RW'(1);
          end
        end
        DRAIN: begin
          if (out_rdy) begin
            if (r == RW'(size - 1)) begin
              r     <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              r <= r + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_SCHED_PERF_EN
  // Saturating count of FEED stall cycles for the current tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == CLEAR) begin
      stall_cnt <= '0;
    end else if (in_feed && stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Bench for systolic_tile_sched (size=4, depth=8): directed tiles plus random
// FIFO-empty / back-pressure tiles, compared each cycle to a read-count model.
module tb_systolic_tile_sched;
  localparam int SIZE  = 4;
  localparam int DEPTH = 8;
  localparam int KW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(SIZE);
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, acc_clr, mac_en, out_val;
  logic          out_rdy = 1'b1;
  logic [RW-1:0] out_row;
  logic          x_empty [SIZE];
  logic          w_empty [SIZE];
  logic          x_ren   [SIZE];
  logic          w_ren   [SIZE];
`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  systolic_tile_sched #(.size(SIZE), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .acc_clr(acc_clr), .mac_en(mac_en),
    .x_fifo_empty(x_empty), .w_fifo_empty(w_empty),
    .x_fifo_ren(x_ren), .w_fifo_ren(w_ren),
    .out_val(out_val), .out_rdy(out_rdy), .out_row(out_row)
`ifdef SYSTOLIC_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: tile progress tracked as reads per lane, MAC count and
  // rows delivered; phase is inferred from those totals.
  bit m_busy, m_cleared, m_done;
  int m_k, m_adv, m_macs, m_rows, m_stalls;
  int rd [SIZE];
  // Observed totals per tile
  int o_xren [SIZE];
  int o_wren [SIZE];
  int o_mac, o_xfer, o_done;
  int hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_read();
    for (int i = 0; i < SIZE; i++) if (rd[i] < m_k) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit m_feed();
    return m_busy && m_cleared && m_k > 0 && !all_read();
  endfunction
  function automatic bit m_flush();
    return m_busy && m_cleared && m_k > 0 && all_read() && m_macs < m_k + 2*(SIZE-1);
  endfunction
  function automatic bit m_drain();
    return m_busy && m_cleared && !m_feed() && !m_flush();
  endfunction
  function automatic bit m_due(input int i);
    return m_feed() && m_adv >= i && rd[i] < m_k;
  endfunction
  function automatic bit m_stall();
    for (int i = 0; i < SIZE; i++) if (m_due(i) && (x_empty[i] || w_empty[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cleared = 0; m_done = 0;
    m_k = 0; m_adv = 0; m_macs = 0; m_rows = 0; m_stalls = 0;
    for (int i = 0; i < SIZE; i++) rd[i] = 0;
  endtask

  task automatic model_update();
    bit stl, was_done;
    bit dm [SIZE];
    if (!rst) begin model_reset(); return; end
    stl = m_stall();
    for (int i = 0; i < SIZE; i++) dm[i] = m_due(i);
    was_done = m_done;
    m_done = 0;
    if (!m_busy) begin
      if (start && !was_done) begin
        m_busy = 1; m_cleared = 0;
        m_k = (int'(k_len) > DEPTH) ? DEPTH : int'(k_len);
        m_adv = 0; m_macs = 0; m_rows = 0;
        for (int i = 0; i < SIZE; i++) rd[i] = 0;
      end
    end else if (!m_cleared) begin
      m_cleared = 1; m_stalls = 0;
    end else if (m_feed()) begin
      if (!stl) begin
        for (int i = 0; i < SIZE; i++) if (dm[i]) rd[i]++;
        m_adv++; m_macs++;
      end else begin
        m_stalls++;
      end
    end else if (m_flush()) begin
      m_macs++;
    end else if (out_rdy) begin
      m_rows++;
      if (m_rows == SIZE) begin m_busy = 0; m_done = 1; end
    end
  endtask

  task automatic check_outputs();
    logic [SIZE-1:0] exr, oxr, owr;
    bit stl;
    stl = m_stall();
    for (int i = 0; i < SIZE; i++) begin
      exr[i] = m_due(i) && !stl;
      oxr[i] = x_ren[i];
      owr[i] = w_ren[i];
    end
    chk("busy", busy, m_busy);
    chk("acc_clr", acc_clr, m_busy && !m_cleared);
    chk("mac_en", mac_en, (m_feed() && !stl) || m_flush());
    chk("out_val", out_val, m_drain());
    chk("out_row", out_row, m_drain() ? m_rows : 0);
    chk("done", done, m_done);
    chk("x_ren", oxr, exr);
    chk("w_ren", owr, exr);
`ifdef SYSTOLIC_SCHED_PERF_EN
    chk("stall_cnt", stall_cnt, m_stalls);
`endif
    for (int i = 0; i < SIZE; i++) begin
      o_xren[i] += int'(x_ren[i]);
      o_wren[i] += int'(w_ren[i]);
    end
    if (mac_en === 1'b1) o_mac++;
    if (out_val === 1'b1 && out_rdy) o_xfer++;
    if (done === 1'b1) o_done++;
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < SIZE; i++) begin x_empty[i] = 1'b0; w_empty[i] = 1'b0; end
    out_rdy = 1'b1;
    start = 1'b0;
  endtask

  // mode 0 clean, 1 x[2] empty 3 cycles at t=2, 2 out_rdy low 5 cycles at row 1,
  // 3 random empties/ready, 4 start held during FEED and the done cycle
  task automatic apply_stim(input int mode);
    clear_inputs();
    case (mode)
      1: if (m_feed() && m_adv == 2 && hold < 3) begin x_empty[2] = 1'b1; hold++; end
      2: if (m_drain() && m_rows == 1 && hold < 5) begin out_rdy = 1'b0; hold++; end
      3: begin
        for (int i = 0; i < SIZE; i++) begin
          x_empty[i] = ($urandom_range(0, 5) == 0);
          w_empty[i] = ($urandom_range(0, 5) == 0);
        end
        out_rdy = ($urandom_range(0, 2) != 0);
      end
      4: start = m_feed() || m_done;
      default: ;
    endcase
  endtask

  task automatic run_tile(input int k, input int mode);
    int budget, ke;
    for (int i = 0; i < SIZE; i++) begin o_xren[i] = 0; o_wren[i] = 0; end
    o_mac = 0; o_xfer = 0; o_done = 0; hold = 0; budget = 0;
    clear_inputs();
    k_len = KW'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    while ((m_busy || m_done) && budget < BUDGET) begin
      apply_stim(mode);
      step();
      budget++;
    end
    clear_inputs();
    chk("tile_timeout", budget < BUDGET, 1);
    ke = (k > DEPTH) ? DEPTH : k;
    for (int i = 0; i < SIZE; i++) begin
      chk("x_ren_total", o_xren[i], ke);
      chk("w_ren_total", o_wren[i], ke);
    end
    chk("mac_total", o_mac, (ke == 0) ? 0 : ke + 2*(SIZE-1));
    chk("transfers", o_xfer, SIZE);
    chk("done_pulses", o_done, 1);
  endtask

  initial begin
    int budget;
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_out_row", out_row, 0);
    repeat (3) step();
    rst = 1'b1;
    step();

    // Basic, stalled, back-pressured and zero-length tiles
    run_tile(3, 0);
    run_tile(3, 1);
`ifdef SYSTOLIC_SCHED_PERF_EN
    chk("stall_cnt_tile", stall_cnt, 3);
`endif
    run_tile(3, 2);
    run_tile(0, 0);

    // Reset in the middle of FEED at t=4
    k_len = KW'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while (!(m_feed() && m_adv == 4) && budget < 50) begin step(); budget++; end
    chk("reach_t4", budget < 50, 1);
    chk("feeding_before_rst", mac_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_acc_clr", acc_clr, 0);
    chk("midrst_out_val", out_val, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out_row", out_row, 0);
    chk("midrst_x_ren0", x_ren[0], 0);
    chk("midrst_w_ren3", w_ren[3], 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
    chk("midrst_stall_cnt", stall_cnt, 0);
`endif
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    step();
    run_tile(4, 0);

    // Clamp, ignored starts, then random tiles
    run_tile(12, 0);
    run_tile(5, 4);
    repeat (6) run_tile($urandom_range(0, 15), 3);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
